// File: rtl/rlbp_rx_pkg.sv
// Shared types and defaults for the RLBP code receiver.
package rlbp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_DONE = 2'd2
  } rx_state_e;

  localparam int DEF_CODE_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_W      = 16;

  // Code bit index that the idx-th received bit (0-based) lands in.
  function automatic int bit_pos(input int code_w, input bit msb_first, input int idx);
    return msb_first ? (code_w - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/rlbp_rx_fifo.sv
// Synchronous FIFO with registered storage and a first-word-fall-through head.
module rlbp_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign level    = level_q;
  assign pop_data = mem[rd_ptr_q];

  // A pop from a full FIFO frees the slot the simultaneous push writes into.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr_q] <= push_data;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/rlbp_code_rx.sv
// Deserialises RLBP comparator bit streams into codes, queues them, and tracks framing health.
module rlbp_code_rx
  import rlbp_rx_pkg::*;
#(
  parameter int CODE_W     = DEF_CODE_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start_i,
  input  logic                          bit_vld_i,
  input  logic                          bit_i,
  input  logic                          done_i,
  output logic [CODE_W-1:0]             code_o,
  output logic                          code_vld_o,
  input  logic                          code_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          ovf_o,
  output logic                          frm_err_o,
  input  logic                          clr_i,
  output logic [CNT_W-1:0]              frame_cnt_o
);

  localparam int CW = $clog2(CODE_W + 1);

  // Handshake: code_o/code_vld_o hold steady until taken; a transfer happens on
  // any rising edge where code_vld_o && code_rdy_i, and code_rdy_i while empty is a no-op.

  rx_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CODE_W-1:0] sreg_q, sreg_d, sreg_nxt;
  logic              push, err_set, frame_inc;
  logic              pop, fifo_full, fifo_empty, ovf_set;
  logic              ovf_q, frm_err_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      ovf_q       <= 1'b0;
      frm_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      // Set events beat a simultaneous clear.
      if (ovf_set)    ovf_q <= 1'b1;
      else if (clr_i) ovf_q <= 1'b0;
      if (err_set)    frm_err_q <= 1'b1;
      else if (clr_i) frm_err_q <= 1'b0;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

  // Shift register image with the current bit dropped into its slot.
  always_comb begin
    sreg_nxt = sreg_q;
    for (int i = 0; i < CODE_W; i++) begin
      if (i == bit_pos(CODE_W, MSB_FIRST, int'(cnt_q))) sreg_nxt[i] = bit_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    err_set   = 1'b0;
    frame_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      end
      SHIFT: begin
        if (start_i) begin
          err_set = 1'b1;
          cnt_d   = '0;
          sreg_d  = '0;
        end else if (bit_vld_i) begin
          sreg_d = sreg_nxt;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(CODE_W - 1)) begin
            push = 1'b1;
            if (done_i) begin
              frame_inc = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = WAIT_DONE;
            end
          end else if (done_i) begin
            err_set = 1'b1;
            state_d = IDLE;
          end
        end else if (done_i) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (start_i) begin
          err_set = 1'b1;
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = '0;
        end else begin
          if (bit_vld_i) err_set = 1'b1;
          if (done_i) begin
            frame_inc = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    ovf_o       = ovf_q;
    frm_err_o   = frm_err_q;
    frame_cnt_o = frame_cnt_q;
    code_vld_o  = !fifo_empty;
  end

  assign pop     = code_vld_o && code_rdy_i;
  assign ovf_set = push && fifo_full && !pop;

  rlbp_rx_fifo #(
    .W     (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data (sreg_nxt),
    .pop       (pop),
    .pop_data  (code_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_o)
  );

endmodule
